// File: rtl/dff_mon_pkg.sv
// Shared types and helpers for the flop-output monitor slice.
// Debounce state encoding and counter sizing.
package dff_mon_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_CHK_HIGH,
    S_HIGH,
    S_CHK_LOW
  } db_state_t;

  function automatic int stab_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dff_edge_debounce_sat_counter.sv
// Saturating up-counter with synchronous clear.
// The sat flag is registered alongside the count so both change together.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= &cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/dff_edge_debounce.sv
// Debounces a flop q/qbar pair into a clean level with edge pulses,
// a saturating edge count and a sticky complement-violation flag.
module dff_edge_debounce
  import dff_mon_pkg::*;
#(
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             q_in,
  input  logic             qbar_in,
  input  logic             clr,
  output logic             db_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_sat,
  output logic             pair_err
);

  localparam int SW = stab_w(STABLE_CYCLES);
  localparam logic [SW-1:0] LAST = SW'(STABLE_CYCLES - 1);

  db_state_t     state_q, state_d;
  logic [SW-1:0] stab_q, stab_d;
  logic          db_q, db_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          pair_q, pair_d;

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    unique case (state_q)
      S_LOW: begin
        if (q_in) begin
          state_d = S_CHK_HIGH;
          stab_d  = SW'(1);
        end
      end
      S_CHK_HIGH: begin
        if (!q_in) begin
          state_d = S_LOW;
          stab_d  = '0;
        end else if (stab_q == LAST) begin
          state_d = S_HIGH;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (!q_in) begin
          state_d = S_CHK_LOW;
          stab_d  = SW'(1);
        end
      end
      S_CHK_LOW: begin
        if (q_in) begin
          state_d = S_HIGH;
          stab_d  = '0;
        end else if (stab_q == LAST) begin
          state_d = S_LOW;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      default: begin
        state_d = S_LOW;
        stab_d  = '0;
      end
    endcase
    rise_d = (state_q == S_CHK_HIGH) && (state_d == S_HIGH);
    fall_d = (state_q == S_CHK_LOW) && (state_d == S_LOW);
    db_d   = (state_d == S_HIGH) || (state_d == S_CHK_LOW);
    // clr dominates a violation sampled on the same edge
    pair_d = clr ? 1'b0 : (pair_q | (q_in ~^ qbar_in));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_LOW;
      stab_q  <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      pair_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pair_q  <= pair_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc_i(rise_q | fall_q),
    .clr_i(clr),
    .cnt_o(edge_cnt),
    .sat_o(cnt_sat)
  );

  assign db_out     = db_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign pair_err   = pair_q;

  always @(posedge clk) begin
    if (rstn) begin
      assert (!(rise_q && fall_q))
        $info("pulse exclusivity held");
      else
        $error("rise and fall pulses high together");
      assert (db_q == (state_q inside {S_HIGH, S_CHK_LOW}))
        $info("db level consistent with state");
      else
        $error("db level inconsistent with state");
      assert (int'(stab_q) < STABLE_CYCLES)
        $info("stability count in range");
      else
        $error("stability count out of range");
    end
  end

endmodule

// File: tb/tb_dff_edge_debounce.sv
// Randomized bench for dff_edge_debounce against a sample-history model
// plus directed checks of glitch, saturation, pair, reset and clr cases.
module tb_dff_edge_debounce;

  localparam int N = 3;
  localparam int W = 3;
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         q_in = 1'b0;
  logic         qbar_in = 1'b1;
  logic         clr = 1'b0;
  logic         db_out, rise_pulse, fall_pulse, cnt_sat, pair_err;
  logic [W-1:0] edge_cnt;

  dff_edge_debounce #(
    .STABLE_CYCLES(N),
    .CNT_W        (W)
  ) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .q_in      (q_in),
    .qbar_in   (qbar_in),
    .clr       (clr),
    .db_out    (db_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .edge_cnt  (edge_cnt),
    .cnt_sat   (cnt_sat),
    .pair_err  (pair_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit m_db, m_rise, m_fall, m_sat, m_pair;
  int m_cnt;
  bit hist[$];

  function automatic logic [7:0] obs();
    return {db_out, rise_pulse, fall_pulse, edge_cnt, cnt_sat, pair_err};
  endfunction

  function automatic logic [7:0] expv();
    return {m_db, m_rise, m_fall, 3'(m_cnt), m_sat, m_pair};
  endfunction

  task automatic model_reset();
    m_db = 0; m_rise = 0; m_fall = 0;
    m_sat = 0; m_pair = 0; m_cnt = 0;
    hist.delete();
  endtask

  // db flips once the last N samples since the previous flip all differ from it
  task automatic tick(input bit q, input bit qb, input bit c);
    bit flip;
    q_in = q; qbar_in = qb; clr = c;
    @(posedge clk);
    if (rstn) begin
      if (c) m_cnt = 0;
      else if ((m_rise || m_fall) && m_cnt < MAXC) m_cnt++;
      m_sat = (m_cnt == MAXC);
      m_pair = !c && (m_pair || (q == qb));
      m_rise = 0; m_fall = 0;
      hist.push_back(q);
      if (hist.size() > N) void'(hist.pop_front());
      if (hist.size() == N) begin
        flip = 1;
        foreach (hist[i]) if (hist[i] == m_db) flip = 0;
        if (flip) begin
          m_db = !m_db;
          if (m_db) m_rise = 1;
          else m_fall = 1;
          hist.delete();
        end
      end
    end
    #1;
  endtask

  task automatic settle_low();
    repeat (4) tick(0, 1, 0);
  endtask

  task automatic test_reset();
    model_reset();
    rstn = 0;
    repeat (3) begin
      tick($urandom_range(0, 1), $urandom_range(0, 1), 0);
      checks++;
      if (obs() !== 8'h00) begin
        errors++;
        $display("FAIL reset got=%b exp=%b", obs(), 8'h00);
      end
    end
    rstn = 1;
  endtask

  task automatic test_clean_edges();
    bit qv;
    int pulses;
    qv = 0;
    pulses = 0;
    tick(0, 1, 1);
    for (int k = 0; k < 6; k++) begin
      qv = !qv;
      repeat ($urandom_range(3, 7)) begin
        tick(qv, !qv, 0);
        if (rise_pulse || fall_pulse) pulses++;
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL clean_edge t=%0t got=%b exp=%b", $time, obs(), expv());
        end
      end
    end
    tick(qv, !qv, 0);
    checks++;
    if (pulses != 6 || edge_cnt !== 3'd6 || pair_err !== 1'b0) begin
      errors++;
      $display("FAIL clean_count pulses=%0d cnt=%0d pair=%b exp 6 6 0",
               pulses, edge_cnt, pair_err);
    end
  endtask

  task automatic test_glitch();
    settle_low();
    tick(0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      tick(i < 2, i >= 2, 0);
      checks++;
      if (db_out !== 1'b0 || rise_pulse !== 1'b0 || edge_cnt !== 3'd0) begin
        errors++;
        $display("FAIL glitch i=%0d db=%b rise=%b cnt=%0d exp 0 0 0",
                 i, db_out, rise_pulse, edge_cnt);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0);
      checks++;
      if (rise_pulse !== (i == 2) || db_out !== (i == 2) ||
          obs() !== expv()) begin
        errors++;
        $display("FAIL glitch_rise i=%0d got=%b exp=%b", i, obs(), expv());
      end
    end
  endtask

  task automatic test_saturation();
    bit qv;
    settle_low();
    tick(0, 1, 1);
    qv = 0;
    for (int e = 0; e < 9; e++) begin
      qv = !qv;
      repeat (3) begin
        tick(qv, !qv, 0);
        checks++;
        if (obs() !== expv()) begin
          errors++;
          $display("FAIL sat_seq e=%0d got=%b exp=%b", e, obs(), expv());
        end
      end
    end
    tick(qv, !qv, 0);
    checks++;
    if (edge_cnt !== 3'd7 || cnt_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold cnt=%0d sat=%b exp 7 1", edge_cnt, cnt_sat);
    end
    tick(qv, !qv, 1);
    checks++;
    if (edge_cnt !== 3'd0 || cnt_sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_clr cnt=%0d sat=%b exp 0 0", edge_cnt, cnt_sat);
    end
  endtask

  task automatic test_pair();
    settle_low();
    tick(0, 1, 1);
    tick(1, 1, 0);
    checks++;
    if (pair_err !== 1'b1) begin
      errors++;
      $display("FAIL pair_set got=%b exp=1", pair_err);
    end
    repeat (3) begin
      tick(1, 0, 0);
      checks++;
      if (pair_err !== 1'b1 || obs() !== expv()) begin
        errors++;
        $display("FAIL pair_sticky got=%b exp=%b", obs(), expv());
      end
    end
    tick(0, 0, 1);
    checks++;
    if (pair_err !== 1'b0) begin
      errors++;
      $display("FAIL pair_clr got=%b exp=0", pair_err);
    end
  endtask

  task automatic test_reset_mid();
    settle_low();
    tick(1, 0, 0);
    tick(1, 0, 0);
    #2;
    rstn = 0;
    model_reset();
    #1;
    checks++;
    if (db_out !== 1'b0 || rise_pulse !== 1'b0 || obs() !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_async got=%b exp=%b", obs(), 8'h00);
    end
    tick(1, 0, 0);
    checks++;
    if (obs() !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_hold got=%b exp=%b", obs(), 8'h00);
    end
    rstn = 1;
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0);
      checks++;
      if (rise_pulse !== (i == 2) || db_out !== (i == 2) ||
          obs() !== expv()) begin
        errors++;
        $display("FAIL rst_mid_rise i=%0d got=%b exp=%b", i, obs(), expv());
      end
    end
  endtask

  task automatic test_clr_edge();
    settle_low();
    tick(0, 1, 1);
    for (int e = 0; e < 5; e++) repeat (3) tick(e % 2 == 0, e % 2 != 0, 0);
    checks++;
    if (rise_pulse !== 1'b1 || edge_cnt !== 3'd4) begin
      errors++;
      $display("FAIL clr_edge_pre rise=%b cnt=%0d exp 1 4", rise_pulse, edge_cnt);
    end
    tick(1, 0, 1);
    checks++;
    if (edge_cnt !== 3'd0 || db_out !== 1'b1 || obs() !== expv()) begin
      errors++;
      $display("FAIL clr_edge got=%b exp=%b", obs(), expv());
    end
  endtask

  task automatic test_random();
    bit qv, qb, c;
    int run;
    qv = 0;
    run = 0;
    for (int t = 0; t < 400; t++) begin
      if (run == 0) begin
        qv = $urandom_range(0, 1);
        run = $urandom_range(1, 5);
      end
      run--;
      qb = ($urandom_range(0, 15) == 0) ? qv : !qv;
      c = ($urandom_range(0, 19) == 0);
      tick(qv, qb, c);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        $display("FAIL random t=%0d got=%b exp=%b", t, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_edges();
    test_glitch();
    test_saturation();
    test_pair();
    test_reset_mid();
    test_clr_edge();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
